// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide sequencer.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            res_valid;
  logic [XLEN-1:0] result;

  modport master (
    output start, Funct3, op_a, op_b, flush,
    input  ready, busy, res_valid, result
  );

  modport slave (
    input  start, Funct3, op_a, op_b, flush,
    output ready, busy, res_valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign fix-up in a final cycle and a valid/ready handshake toward EX.
module muldiv_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int unsigned ACC_W = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic             neg_q;
  logic [ACC_W-1:0] acc;
  logic [XLEN-1:0]  opnd;

  logic             sa_c, sb_c, div_by_zero_c, ovf_c, fast_c;
  logic [XLEN-1:0]  mag_a_c, mag_b_c, fast_res_c;
  logic [XLEN:0]    sum_c, shifted_c;
  logic [XLEN-1:0]  diff_c, quo_rem_c, fix_res_c;
  logic [ACC_W-1:0] step_c, prod_c;

  // Accept-time decode: signedness, magnitudes and the div-by-zero / overflow shortcuts
  always_comb begin
    sa_c          = 1'b0;
    sb_c          = 1'b0;
    div_by_zero_c = 1'b0;
    ovf_c         = 1'b0;
    fast_res_c    = '0;
    case (bus.Funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sa_c = bus.op_a[XLEN-1];
        sb_c = bus.op_b[XLEN-1];
      end
      3'b010:  sa_c = bus.op_a[XLEN-1];
      default: ;
    endcase
    mag_a_c = sa_c ? (~bus.op_a + XLEN'(1)) : bus.op_a;
    mag_b_c = sb_c ? (~bus.op_b + XLEN'(1)) : bus.op_b;
    if (bus.Funct3[2]) begin
      div_by_zero_c = (bus.op_b == '0);
      ovf_c = !bus.Funct3[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    end
    if (div_by_zero_c)
      fast_res_c = bus.Funct3[1] ? bus.op_a : '1;
    else if (ovf_c)
      fast_res_c = bus.Funct3[1] ? '0 : bus.op_a;
    fast_c = div_by_zero_c || ovf_c;
  end

  // One iteration: add-shift for multiply, trial subtract for divide (acc = {rem, quotient})
  always_comb begin
    sum_c     = {1'b0, acc[ACC_W-1:XLEN]} + {1'b0, opnd};
    shifted_c = {acc[ACC_W-1:XLEN], acc[XLEN-1]};
    diff_c    = shifted_c[XLEN-1:0] - opnd;
    if (f3_q[2]) begin
      if (shifted_c >= {1'b0, opnd})
        step_c = {diff_c, acc[XLEN-2:0], 1'b1};
      else
        step_c = {shifted_c[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else if (acc[0]) begin
      step_c = {sum_c, acc[XLEN-1:1]};
    end else begin
      step_c = {1'b0, acc[ACC_W-1:1]};
    end
  end

  // Sign fix-up and word selection
  always_comb begin
    prod_c    = neg_q ? (~acc + ACC_W'(1)) : acc;
    quo_rem_c = f3_q[1] ? acc[ACC_W-1:XLEN] : acc[XLEN-1:0];
    if (f3_q[2])
      fix_res_c = neg_q ? (~quo_rem_c + XLEN'(1)) : quo_rem_c;
    else if (f3_q == 3'b000)
      fix_res_c = prod_c[XLEN-1:0];
    else
      fix_res_c = prod_c[ACC_W-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_q          <= '0;
      neg_q         <= 1'b0;
      acc           <= '0;
      opnd          <= '0;
      bus.ready     <= 1'b1;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.result    <= '0;
    end else begin
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.ready && !bus.flush) begin
            f3_q      <= bus.Funct3;
            neg_q     <= (bus.Funct3[2:1] == 2'b11) ? sa_c : (sa_c ^ sb_c);
            bus.ready <= 1'b0;
            bus.busy  <= 1'b1;
            cnt       <= '0;
            if (fast_c) begin
              state         <= DONE;
              bus.result    <= fast_res_c;
              bus.res_valid <= 1'b1;
            end else begin
              state <= CALC;
              acc   <= bus.Funct3[2] ? {{XLEN{1'b0}}, mag_a_c} : {{XLEN{1'b0}}, mag_b_c};
              opnd  <= bus.Funct3[2] ? mag_b_c : mag_a_c;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state     <= IDLE;
            cnt       <= '0;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
          end else begin
            acc <= step_c;
            if (cnt == CNT_W'(XLEN - 1)) begin
              state <= FIX;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        FIX: begin
          if (bus.flush) begin
            state     <= IDLE;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
          end else begin
            state         <= DONE;
            bus.result    <= fix_res_c;
            bus.res_valid <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: results, latency, fast paths, flush, reset and held start.
module tb_muldiv_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic [31:0] last_res;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a request in the current cycle (T); return positioned #1 into cycle T+1
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.Funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // Called #1 into cycle T+1; waits for res_valid and checks latency, value and pulse width
  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int k;
    bit seen;
    k = 1;
    seen = 1'b0;
    while (k <= 60 && !seen) begin
      if (k == 1) check({tag, " busy@T+1"}, 64'(bus.busy), 64'(1));
      if (bus.res_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    check({tag, " latency"}, seen ? 64'(k) : 64'(0), 64'(exp_lat));
    check({tag, " result"}, 64'(bus.result), 64'(exp_res));
    last_res = exp_res;
    @(posedge clk); #1;
    check({tag, " pulse_end"}, 64'(bus.res_valid), 64'(0));
    check({tag, " ready_after"}, 64'(bus.ready), 64'(1));
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    issue(f3, a, b);
    wait_result(tag, exp_lat, exp_res);
  endtask

  initial begin
    int pulses;
    n_checks  = 0;
    n_pass    = 0;
    last_res  = 32'h0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.Funct3 = 3'b000;
    bus.op_a  = 32'h0;
    bus.op_b  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 64'(bus.ready), 64'(1));
    check("rst busy", 64'(bus.busy), 64'(0));
    check("rst res_valid", 64'(bus.res_valid), 64'(0));
    check("rst result", 64'(bus.result), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("MUL 7*-3",      3'b000, 32'd7,          32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
    run_op("MULH min*min",  3'b001, 32'h8000_0000,  32'h8000_0000, 34, 32'h4000_0000);
    run_op("MULHU min*min", 3'b011, 32'h8000_0000,  32'h8000_0000, 34, 32'h4000_0000);
    run_op("MULHSU -1*2",   3'b010, 32'hFFFF_FFFF,  32'd2,         34, 32'hFFFF_FFFF);
    run_op("DIV -7/2",      3'b100, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFD);
    run_op("REM -7/2",      3'b110, 32'hFFFF_FFF9,  32'd2,         34, 32'hFFFF_FFFF);
    run_op("DIVU 100/7",    3'b101, 32'd100,        32'd7,         34, 32'd14);
    run_op("REMU 100/7",    3'b111, 32'd100,        32'd7,         34, 32'd2);
    run_op("DIV 5/0",       3'b100, 32'd5,          32'd0,         1,  32'hFFFF_FFFF);
    run_op("REMU 5/0",      3'b111, 32'd5,          32'd0,         1,  32'd5);
    run_op("DIV ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000);
    run_op("REM ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h0);

    // Flush at T+10: back in IDLE at T+11, no result, previous result retained
    issue(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush ready", 64'(bus.ready), 64'(1));
    check("flush busy", 64'(bus.busy), 64'(0));
    check("flush res_valid", 64'(bus.res_valid), 64'(0));
    check("flush result", 64'(bus.result), 64'(last_res));
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.res_valid) pulses++;
    end
    check("flush no pulse", 64'(pulses), 64'(0));

    // Flush beats start in IDLE
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush prio busy", 64'(bus.busy), 64'(0));

    // Reset mid-operation at T+20
    issue(3'b101, 32'd100, 32'd7);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst ready", 64'(bus.ready), 64'(1));
    check("midrst busy", 64'(bus.busy), 64'(0));
    check("midrst res_valid", 64'(bus.res_valid), 64'(0));
    check("midrst result", 64'(bus.result), 64'(0));
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.res_valid) pulses++;
    end
    check("midrst no pulse", 64'(pulses), 64'(0));

    // start held through busy with new operands: ignored until the first IDLE cycle
    bus.start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.op_a   = 32'd3;
    bus.op_b   = 32'd5;
    @(posedge clk); #1;
    bus.Funct3 = 3'b101;
    bus.op_a   = 32'd100;
    bus.op_b   = 32'd7;
    begin
      int k;
      bit seen;
      k = 1;
      seen = 1'b0;
      while (k <= 60 && !seen) begin
        if (bus.res_valid) seen = 1'b1;
        else begin
          @(posedge clk); #1;
          k++;
        end
      end
      check("held first latency", seen ? 64'(k) : 64'(0), 64'(34));
      check("held first result", 64'(bus.result), 64'(15));
    end
    @(posedge clk); #1;
    check("held idle ready", 64'(bus.ready), 64'(1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_result("held second", 34, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
